// File: rtl/systolic_sequencer_pkg.sv
// Shared types and constants for the systolic_sequencer slice.
package systolic_sequencer_pkg;

  // Job phases of the sequencer.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    PRIME = 3'd4,
    READ  = 3'd5
  } state_t;

  // Default array dimension.
  localparam int SEQ_N = 8;

  // Zero beats needed to drain the skew and the array diagonal.
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

  localparam int FLUSH_LEN = flush_len(SEQ_N);

endpackage

// File: rtl/systolic_sequencer_if.sv
// Operand and result valid/ready streams of the systolic_sequencer.
interface systolic_sequencer_if #(
  parameter int N = 8
);
  logic         op_valid;
  logic         op_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_last;

  // Producer of operands / consumer of result rows.
  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data, res_last
  );

  // The sequencer side.
  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data, res_last
  );
endinterface

// File: rtl/systolic_sequencer_skew_line.sv
// Per-lane skew: lane b emits its head value delayed by b enabled beats.
module systolic_sequencer_skew_line #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [N-1:0] head,
  output logic [N-1:0] skewed
);

  assign skewed[0] = head[0];

  for (genvar b = 1; b < N; b++) begin : g_lane
    logic [b-1:0] sr_r;

    if (b == 1) begin : g_single
      // Single-stage lane: capture the head bit on each enabled beat.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sr_r <= '0;
        end else if (clear) begin
          sr_r <= '0;
        end else if (enable) begin
          sr_r <= head[b:b];
        end
      end
    end else begin : g_multi
      // Multi-stage lane: shift the head bit in on each enabled beat.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sr_r <= '0;
        end else if (clear) begin
          sr_r <= '0;
        end else if (enable) begin
          sr_r <= {sr_r[b-2:0], head[b]};
        end
      end
    end

    assign skewed[b] = sr_r[b-1];
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for one bit-matrix product on the NxN systolic array:
// clear, skewed operand feed, flush, prime, then backpressured row readout.
module systolic_sequencer
  import systolic_sequencer_pkg::*;
#(
  parameter int N  = SEQ_N,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] cfg_k,
  input  logic          cfg_xor,
  systolic_sequencer_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          sa_reset,
  output logic          sa_valid,
  output logic          sa_readout,
  output logic          sa_usexor,
  output logic [N-1:0]  sa_in1,
  output logic [N-1:0]  sa_in2,
  input  logic [N-1:0]  sa_out
);

  localparam int FL = flush_len(N);
  localparam int FW = $clog2(2 * N);
  localparam int RW = $clog2(N);

  state_t        state_r;
  state_t        state_s;
  logic [KW-1:0] k_rem_r;
  logic [FW-1:0] flush_cnt_r;
  logic [RW-1:0] row_r;
  logic          usexor_r;
  logic          res_valid_r;
  logic [N-1:0]  res_data_r;
  logic          res_last_r;
  logic          done_r;

  logic          op_ready_s;
  logic          accept_s;
  logic          sa_valid_s;
  logic          readout_s;
  logic          clear_s;
  logic          busy_s;
  logic [N-1:0]  head_a_s;
  logic [N-1:0]  head_b_s;
  logic          consume_s;
  logic          last_consume_s;

  assign consume_s      = res_valid_r & bus.res_ready;
  assign last_consume_s = consume_s & (row_r == RW'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CLEAR;
        else       state_s = IDLE;
      end
      CLEAR: begin
        if (k_rem_r != '0) state_s = FEED;
        else               state_s = FLUSH;
      end
      FEED: begin
        if (accept_s && (k_rem_r == KW'(1))) state_s = FLUSH;
        else                                 state_s = FEED;
      end
      FLUSH: begin
        if (flush_cnt_r == FW'(FL - 1)) state_s = PRIME;
        else                            state_s = FLUSH;
      end
      PRIME: begin
        state_s = READ;
      end
      READ: begin
        if (last_consume_s) state_s = IDLE;
        else                state_s = READ;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Per-state array controls and stream handshakes.
  always_comb begin
    op_ready_s = 1'b0;
    accept_s   = 1'b0;
    sa_valid_s = 1'b0;
    readout_s  = 1'b0;
    clear_s    = 1'b0;
    busy_s     = 1'b1;
    head_a_s   = '0;
    head_b_s   = '0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      CLEAR: begin
        clear_s = 1'b1;
      end
      FEED: begin
        op_ready_s = 1'b1;
        accept_s   = bus.op_valid;
        sa_valid_s = bus.op_valid;
        if (bus.op_valid) begin
          head_a_s = bus.op_a;
          head_b_s = bus.op_b;
        end else begin
          head_a_s = '0;
          head_b_s = '0;
        end
      end
      FLUSH: begin
        sa_valid_s = 1'b1;
      end
      PRIME: begin
        readout_s = 1'b1;
      end
      READ: begin
        // Pull the next row only into an empty or draining output register.
        if (!res_valid_r || (consume_s && !last_consume_s)) readout_s = 1'b1;
        else                                                readout_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Job configuration latch and remaining-beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_rem_r  <= '0;
      usexor_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      k_rem_r  <= cfg_k;
      usexor_r <= cfg_xor;
    end else if (accept_s) begin
      k_rem_r  <= k_rem_r - KW'(1);
    end
  end

  // Flush length counter, held at zero outside FLUSH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt_r <= '0;
    end else if (state_r == FLUSH) begin
      flush_cnt_r <= flush_cnt_r + FW'(1);
    end else begin
      flush_cnt_r <= '0;
    end
  end

  // Row counter: index of the beat currently offered on res_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_r <= '0;
    end else if (state_r == PRIME) begin
      row_r <= '0;
    end else if ((state_r == READ) && consume_s && !last_consume_s) begin
      row_r <= row_r + RW'(1);
    end
  end

  // Result output register and end-of-job pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_last_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= (state_r == READ) && last_consume_s;
      if ((state_r == READ) && readout_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= sa_out;
        if (!res_valid_r) res_last_r <= (row_r == RW'(N - 1));
        else              res_last_r <= (row_r == RW'(N - 2));
      end else if (last_consume_s) begin
        res_valid_r <= 1'b0;
        res_last_r  <= 1'b0;
      end
    end
  end

  systolic_sequencer_skew_line #(.N(N)) u_skew_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_s),
    .enable (sa_valid_s),
    .head   (head_a_s),
    .skewed (sa_in1)
  );

  systolic_sequencer_skew_line #(.N(N)) u_skew_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_s),
    .enable (sa_valid_s),
    .head   (head_b_s),
    .skewed (sa_in2)
  );

  assign sa_reset      = !rst_n | clear_s;
  assign sa_valid      = sa_valid_s;
  assign sa_readout    = readout_s;
  assign sa_usexor     = usexor_r;
  assign busy          = busy_s;
  assign done          = done_r;
  assign bus.op_ready  = op_ready_s;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_last  = res_last_r;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: a behavioural array stub drives sa_out,
// result rows are checked against a direct OR/XOR product of the operands.
module tb_systolic_sequencer;
  localparam int N  = 8;
  localparam int KW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] cfg_k;
  logic          cfg_xor;
  logic          busy, done, sa_reset, sa_valid, sa_readout, sa_usexor;
  logic [N-1:0]  sa_in1, sa_in2, sa_out;

  systolic_sequencer_if #(.N(N)) bus_if ();

  systolic_sequencer #(.N(N), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_xor(cfg_xor),
    .bus(bus_if), .busy(busy), .done(done), .sa_reset(sa_reset),
    .sa_valid(sa_valid), .sa_readout(sa_readout), .sa_usexor(sa_usexor),
    .sa_in1(sa_in1), .sa_in2(sa_in2), .sa_out(sa_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_err    = 0;
  logic [N-1:0] ja [64];
  logic [N-1:0] jb [64];
  logic [N-1:0] exp_q [$];
  logic [N-1:0] got_q [$];
  int           rows_seen;
  bit           exp_done_next;
  int           job_done_cnt = 0;
  bit           chk_en = 1'b0;
  int           nvalid, nread, nreset;
  bit           saw_ready;
  bit           prev_stall;
  logic [N-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural NxN array stub ----------------
  // a flows down rows from sa_in1[j], b flows across columns from sa_in2[i].
  logic [N-1:0] acc   [N];
  logic [N-1:0] a_reg [N];
  logic [N-1:0] b_reg [N];
  logic [N-1:0] chain [N];
  bit           loaded;

  function automatic logic a_in(input int i, input int j);
    if (i == 0) return sa_in1[j];
    return a_reg[i-1][j];
  endfunction

  function automatic logic b_in(input int i, input int j);
    if (j == 0) return sa_in2[i];
    return b_reg[i][j-1];
  endfunction

  assign sa_out = chain[N-1];

  always @(posedge clk) begin
    if (sa_reset) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0; a_reg[i] <= '0; b_reg[i] <= '0; chain[i] <= '0;
      end
      loaded <= 1'b0;
    end else if (sa_valid) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= a_in(i, j);
          b_reg[i][j] <= b_in(i, j);
          acc[i][j]   <= sa_usexor ? (acc[i][j] ^ (a_in(i, j) & b_in(i, j)))
                                   : (acc[i][j] | (a_in(i, j) & b_in(i, j)));
        end
      end
    end else if (sa_readout) begin
      if (!loaded) begin
        for (int i = 0; i < N; i++) chain[i] <= acc[i];
        loaded <= 1'b1;
      end else begin
        chain[0] <= '0;
        for (int i = 1; i < N; i++) chain[i] <= chain[i-1];
      end
    end
  end

  // ---------------- reference: row i bit j = reduce_k a_k[j] & b_k[i] ----------------
  function automatic logic [N-1:0] model_row(input int i, input int k, input bit x);
    logic [N-1:0] r;
    r = '0;
    for (int kk = 0; kk < k; kk++)
      for (int j = 0; j < N; j++)
        r[j] = x ? (r[j] ^ (ja[kk][j] & jb[kk][i])) : (r[j] | (ja[kk][j] & jb[kk][i]));
    return r;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic [N-1:0] e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("valid_readout_excl", 32'(sa_valid & sa_readout), 32'd0);
        if (!busy) chk("idle_op_ready", 32'(bus_if.op_ready), 32'd0);
        if (bus_if.op_ready && !bus_if.op_valid) chk("gap_sa_valid", 32'(sa_valid), 32'd0);
        if (bus_if.res_valid && !bus_if.res_ready) chk("stall_readout", 32'(sa_readout), 32'd0);
        if (prev_stall) begin
          chk("stall_res_valid", 32'(bus_if.res_valid), 32'd1);
          chk("stall_res_data", 32'(bus_if.res_data), 32'(prev_data));
        end
        if (exp_done_next) begin
          chk("done_pulse", 32'(done), 32'd1);
          chk("done_busy", 32'(busy), 32'd0);
          exp_done_next = 1'b0;
          job_done_cnt++;
        end else begin
          chk("done_quiet", 32'(done), 32'd0);
        end
        if (bus_if.res_valid && bus_if.res_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_row", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("row_data", 32'(bus_if.res_data), 32'(e));
            chk("row_last", 32'(bus_if.res_last), 32'(rows_seen == N - 1));
          end
          got_q.push_back(bus_if.res_data);
          if (rows_seen == N - 1) exp_done_next = 1'b1;
          rows_seen++;
        end
        prev_stall = bus_if.res_valid && !bus_if.res_ready;
        prev_data  = bus_if.res_data;
        nvalid += int'(sa_valid);
        nread  += int'(sa_readout);
        nreset += int'(sa_reset);
        if (bus_if.op_ready) saw_ready = 1'b1;
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    rows_seen     = 0;
    exp_done_next = 1'b0;
    prev_stall    = 1'b0;
  endtask

  task automatic idle_inputs();
    start = 1'b0; cfg_k = '0; cfg_xor = 1'b0;
    bus_if.op_valid = 1'b0; bus_if.op_a = '0; bus_if.op_b = '0; bus_if.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sa_reset", 32'(sa_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op_ready", 32'(bus_if.op_ready), 32'd0);
    chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    chk("rst_res_last", 32'(bus_if.res_last), 32'd0);
    chk("rst_sa_ctl", 32'({sa_valid, sa_readout, sa_usexor}), 32'd0);
    chk("rst_sa_in", 32'({sa_in1, sa_in2}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_sa_reset", 32'(sa_reset), 32'd0);
    clear_model();
    chk_en = 1'b1;
  endtask

  // One job: gap <0 = random 0..3 idle cycles between beats; stall=1 holds
  // res_ready low 5 cycles at beat 3; otherwise res_ready is high rr_pct %.
  task automatic run_job(input int k, input bit x, input int gap, input bit stall, input int rr_pct);
    int  bi, gl, rows_done, stall_left, start_cnt, c;
    bit  fire, rfire, busy_s, resv_s;
    clear_model();
    for (int r = 0; r < N; r++) exp_q.push_back(model_row(N - 1 - r, k, x));
    nvalid = 0; nread = 0; nreset = 0; saw_ready = 1'b0;
    start_cnt = job_done_cnt;
    @(posedge clk); #1;
    start = 1'b1; cfg_k = KW'(k); cfg_xor = x;
    bus_if.op_valid = 1'b0; bus_if.res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    bi = 0; gl = 0; rows_done = 0; stall_left = 5;
    for (c = 0; c < 3000 && job_done_cnt == start_cnt; c++) begin
      @(negedge clk);
      fire   = bus_if.op_valid && bus_if.op_ready;
      rfire  = bus_if.res_valid && bus_if.res_ready;
      busy_s = busy;
      resv_s = bus_if.res_valid;
      @(posedge clk); #1;
      if (fire) begin
        bi++;
        gl = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      end
      if (rfire) rows_done++;
      if (bi < k && gl == 0) begin
        bus_if.op_valid = 1'b1; bus_if.op_a = ja[bi]; bus_if.op_b = jb[bi];
      end else begin
        bus_if.op_valid = ($urandom_range(1, 0) == 1) && (bi >= k);
        bus_if.op_a = N'($urandom); bus_if.op_b = N'($urandom);
        if (gl > 0) gl--;
      end
      // Stray start / config changes while the job is running.
      start   = busy_s && !resv_s && ($urandom_range(5, 0) == 0);
      cfg_k   = KW'($urandom);
      cfg_xor = 1'($urandom);
      if (stall && rows_done == 3 && stall_left > 0) begin
        bus_if.res_ready = 1'b0;
        stall_left--;
      end else if (stall) begin
        bus_if.res_ready = 1'b1;
      end else begin
        bus_if.res_ready = ($urandom_range(99, 0) < rr_pct);
      end
    end
    idle_inputs();
    if (job_done_cnt == start_cnt) begin
      chk("job_timeout", 32'd1, 32'd0);
      do_reset();
    end else begin
      chk("job_rows", 32'(got_q.size()), 32'(N));
      chk("job_sa_valid_beats", 32'(nvalid), 32'(k + 2 * N - 1));
      chk("job_readouts", 32'(nread), 32'(N + 1));
      chk("job_clear_cycles", 32'(nreset), 32'd1);
      if (k == 0) chk("k0_op_ready_seen", 32'(saw_ready), 32'd0);
    end
  endtask

  task automatic chk_rows(input string name, input logic [N-1:0] lit [N]);
    for (int r = 0; r < N; r++)
      chk(name, 32'((r < got_q.size()) ? got_q[r] : 'x), 32'(lit[r]));
  endtask

  logic [N-1:0] lit_ff81 [N];
  logic [N-1:0] lit_zero [N];
  logic [N-1:0] save_q   [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lit_ff81 = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    lit_zero = '{default: 8'h00};
    rst_n = 1'b0;
    do_reset();

    // OR, K=1, a=FF b=81.
    ja[0] = 8'hFF; jb[0] = 8'h81;
    run_job(1, 1'b0, 0, 1'b0, 100);
    chk_rows("t1_or_k1", lit_ff81);

    // XOR, same pair twice -> all zero; OR of same -> as K=1.
    ja[1] = 8'hFF; jb[1] = 8'h81;
    run_job(2, 1'b1, 0, 1'b0, 100);
    chk_rows("t2_xor_k2", lit_zero);
    run_job(2, 1'b0, 0, 1'b0, 100);
    chk_rows("t2_or_k2", lit_ff81);

    // OR, K=3 random operands, gap-free vs 4-cycle gaps.
    for (int i = 0; i < 3; i++) begin ja[i] = N'($urandom); jb[i] = N'($urandom); end
    run_job(3, 1'b0, 0, 1'b0, 100);
    save_q = got_q;
    run_job(3, 1'b0, 4, 1'b0, 100);
    for (int r = 0; r < N; r++) chk("t3_gap_equal", 32'(got_q[r]), 32'(save_q[r]));

    // Result backpressure at beat 3.
    for (int i = 0; i < 5; i++) begin ja[i] = N'($urandom); jb[i] = N'($urandom); end
    run_job(5, 1'b1, 0, 1'b1, 100);

    // K=0: zero rows, no operand handshake.
    run_job(0, 1'b0, 0, 1'b0, 100);
    chk_rows("t5_k0", lit_zero);

    // Reset during FEED, then a fresh job.
    for (int i = 0; i < 4; i++) begin ja[i] = N'($urandom); jb[i] = N'($urandom); end
    @(posedge clk); #1;
    start = 1'b1; cfg_k = 8'd4; cfg_xor = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    bus_if.op_valid = 1'b1; bus_if.op_a = ja[0]; bus_if.op_b = jb[0];
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_op_ready", 32'(bus_if.op_ready), 32'd1);
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    bus_if.op_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_sa_reset", 32'(sa_reset), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_op_ready", 32'(bus_if.op_ready), 32'd0);
    chk("post_rst_sa_valid", 32'(sa_valid), 32'd0);
    chk("post_rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    clear_model();
    chk_en = 1'b1;
    ja[0] = 8'hFF; jb[0] = 8'h81;
    run_job(1, 1'b0, 0, 1'b0, 100);
    chk_rows("t6_after_reset", lit_ff81);

    // Randomized jobs.
    for (int t = 0; t < 20; t++) begin
      int k;
      k = int'($urandom_range(12, 0));
      for (int i = 0; i < k; i++) begin ja[i] = N'($urandom); jb[i] = N'($urandom); end
      run_job(k, 1'($urandom), -1, 1'b0, 70);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
